// File: rtl/decode_queue_if.sv
// Handshake bundle between the fetcher, the decode queue and the dispatcher.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface decode_queue_if #(
  parameter int OP_WIDTH = 7,
  parameter int REG_NUM  = 32
);
  localparam int RW = $clog2(REG_NUM);

  logic                rdy_in;
  logic                flush_in;
  logic                inst_valid_in;
  logic [31:0]         inst_in;
  logic [31:0]         pc_in;
  logic                pred_jump_in;
  logic                inst_ready_out;
  logic                out_valid;
  logic                out_ready;
  logic [OP_WIDTH-1:0] out_op;
  logic [RW-1:0]       out_rd;
  logic [RW-1:0]       out_rs1;
  logic [RW-1:0]       out_rs2;
  logic [31:0]         out_imm;
  logic [31:0]         out_pc;
  logic                out_pred_jump;
  logic [4:0]          out_flags;

  modport slave (
    input  rdy_in, flush_in, inst_valid_in, inst_in, pc_in, pred_jump_in, out_ready,
    output inst_ready_out, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc,
           out_pred_jump, out_flags
  );

  modport master (
    output rdy_in, flush_in, inst_valid_in, inst_in, pc_in, pred_jump_in, out_ready,
    input  inst_ready_out, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc,
           out_pred_jump, out_flags
  );
endinterface

// File: rtl/decode_queue.sv
// Registered RV32I decode stage: decodes on enqueue and buffers 2**QUEUE_WIDTH entries.
// Optional macro DECODE_QUEUE_BYPASS_EN: an empty queue with a ready dispatcher passes the
// incoming instruction straight to the outputs in the same cycle without storing it.
module decode_queue #(
  parameter int QUEUE_WIDTH = 2,
  parameter int REG_NUM     = 32,
  parameter int OP_WIDTH    = 7
) (
  input logic           clk_in,
  input logic           rst_in,
  decode_queue_if.slave bus
);
  localparam int DEPTH = 1 << QUEUE_WIDTH;
  localparam int RW    = $clog2(REG_NUM);
  localparam logic [QUEUE_WIDTH:0] FULL_CNT = (QUEUE_WIDTH + 1)'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [RW-1:0]       rd;
    logic [RW-1:0]       rs1;
    logic [RW-1:0]       rs2;
    logic [31:0]         imm;
    logic [31:0]         pc;
    logic                pred;
    logic [4:0]          flags;
  } entry_t;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  logic [OP_WIDTH-1:0] d_op;
  logic                use_rd, use_rs1, use_rs2, d_mem, d_br;
  logic [31:0]         d_imm;
  logic                op_ok;
  entry_t              dec;

  entry_t                 store [DEPTH];
  logic [QUEUE_WIDTH-1:0] head, tail;
  logic [QUEUE_WIDTH:0]   count;
  logic                   full, ready, q_valid, bypass, enq, deq;
  entry_t                 shown;

  assign inst   = bus.inst_in;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  // Opcode/funct decode into the internal op number and operand usage.
  always_comb begin
    d_op    = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    d_mem   = 1'b0;
    d_br    = 1'b0;
    d_imm   = '0;
    case (opcode)
      OPC_LUI: begin
        d_op = OP_WIDTH'(1); use_rd = 1'b1; d_imm = imm_u;
      end
      OPC_AUIPC: begin
        d_op = OP_WIDTH'(2); use_rd = 1'b1; d_imm = imm_u;
      end
      OPC_JAL: begin
        d_op = OP_WIDTH'(3); use_rd = 1'b1; d_imm = imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) d_op = OP_WIDTH'(4);
        use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_br = 1'b1; d_imm = imm_b;
        case (funct3)
          3'b000:  d_op = OP_WIDTH'(5);
          3'b001:  d_op = OP_WIDTH'(6);
          3'b100:  d_op = OP_WIDTH'(7);
          3'b101:  d_op = OP_WIDTH'(8);
          3'b110:  d_op = OP_WIDTH'(9);
          3'b111:  d_op = OP_WIDTH'(10);
          default: d_op = '0;
        endcase
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; d_mem = 1'b1; d_imm = imm_i;
        case (funct3)
          3'b000:  d_op = OP_WIDTH'(11);
          3'b001:  d_op = OP_WIDTH'(12);
          3'b010:  d_op = OP_WIDTH'(13);
          3'b100:  d_op = OP_WIDTH'(14);
          3'b101:  d_op = OP_WIDTH'(15);
          default: d_op = '0;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_mem = 1'b1; d_imm = imm_s;
        case (funct3)
          3'b000:  d_op = OP_WIDTH'(16);
          3'b001:  d_op = OP_WIDTH'(17);
          3'b010:  d_op = OP_WIDTH'(18);
          default: d_op = '0;
        endcase
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
        case (funct3)
          3'b000: d_op = OP_WIDTH'(19);
          3'b010: d_op = OP_WIDTH'(20);
          3'b011: d_op = OP_WIDTH'(21);
          3'b100: d_op = OP_WIDTH'(22);
          3'b110: d_op = OP_WIDTH'(23);
          3'b111: d_op = OP_WIDTH'(24);
          3'b001: begin
            d_imm = imm_sh;
            if (funct7 == 7'h00) d_op = OP_WIDTH'(25);
          end
          3'b101: begin
            d_imm = imm_sh;
            if (funct7 == 7'h00)      d_op = OP_WIDTH'(26);
            else if (funct7 == 7'h20) d_op = OP_WIDTH'(27);
          end
          default: d_op = '0;
        endcase
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  d_op = OP_WIDTH'(28);
            3'b001:  d_op = OP_WIDTH'(30);
            3'b010:  d_op = OP_WIDTH'(31);
            3'b011:  d_op = OP_WIDTH'(32);
            3'b100:  d_op = OP_WIDTH'(33);
            3'b101:  d_op = OP_WIDTH'(34);
            3'b110:  d_op = OP_WIDTH'(36);
            default: d_op = OP_WIDTH'(37);
          endcase
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'b000)      d_op = OP_WIDTH'(29);
          else if (funct3 == 3'b101) d_op = OP_WIDTH'(35);
        end
      end
      default: d_op = '0;
    endcase
  end

  // Assemble the entry; an unrecognised word keeps only pc/prediction so it still flows in order.
  always_comb begin
    op_ok     = (d_op != '0);
    dec       = '0;
    dec.pc    = bus.pc_in;
    dec.pred  = bus.pred_jump_in;
    dec.op    = d_op;
    dec.rd    = (op_ok && use_rd)  ? inst[7 +: RW]  : '0;
    dec.rs1   = (op_ok && use_rs1) ? inst[15 +: RW] : '0;
    dec.rs2   = (op_ok && use_rs2) ? inst[20 +: RW] : '0;
    dec.imm   = op_ok ? d_imm : '0;
    dec.flags = {op_ok && use_rd && (inst[7 +: RW] != '0), op_ok && use_rs1,
                 op_ok && use_rs2, op_ok && d_mem, op_ok && d_br};
  end

  assign full    = (count == FULL_CNT);
  assign ready   = bus.rdy_in & ~full & ~rst_in;
  assign q_valid = bus.rdy_in & (count != '0);
`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass  = bus.rdy_in & ~bus.flush_in & (count == '0) & bus.out_ready & ~rst_in;
`else
  assign bypass  = 1'b0;
`endif
  assign enq     = bus.inst_valid_in & ready & ~bypass;
  assign deq     = q_valid & bus.out_ready;

  // Pointer and occupancy update; flush wins over any same-cycle enqueue/dequeue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) tail <= tail + QUEUE_WIDTH'(1);
        if (deq) head <= head + QUEUE_WIDTH'(1);
        if (enq && !deq)      count <= count + (QUEUE_WIDTH + 1)'(1);
        else if (!enq && deq) count <= count - (QUEUE_WIDTH + 1)'(1);
      end
    end
  end

  // Entry storage; cleared on reset so the idle outputs read zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (enq && !bus.flush_in) begin
      store[tail] <= dec;
    end
  end

  // Head entry, or the freshly decoded word when bypassing.
  always_comb begin
    shown = store[head];
    if (bypass) shown = dec;
  end

  assign bus.inst_ready_out = ready;
  assign bus.out_valid      = q_valid | (bypass & bus.inst_valid_in);
  assign bus.out_op         = shown.op;
  assign bus.out_rd         = shown.rd;
  assign bus.out_rs1        = shown.rs1;
  assign bus.out_rs2        = shown.rs2;
  assign bus.out_imm        = shown.imm;
  assign bus.out_pc         = shown.pc;
  assign bus.out_pred_jump  = shown.pred;
  assign bus.out_flags      = shown.flags;
endmodule
